// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, samples
// the synchronized rows once per column dwell, debounces a single pressed key,
// reports its hex code with a one-cycle key_valid pulse and holds key_held
// until the release has been debounced.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t        state_q;
    logic [3:0]    rs_meta_q;
    logic [3:0]    rs_q;
    logic [1:0]    col_q;
    logic [1:0]    row_q;
    logic [3:0]    cols_q;
    logic [3:0]    key_q;
    logic          key_valid_q;
    logic          key_held_q;
    logic [CW-1:0] cnt_q;

    logic [CW-1:0] cnt_inc_d;
    logic [3:0]    cols_rot_d;
    logic [3:0]    row_pat_d;
    logic          one_low_d;
    logic [1:0]    row_idx_d;

    // Hex code for each (row, col) position of the keypad legend.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Saturating counter step, next column drive pattern and captured-row pattern.
    always_comb begin
        cnt_inc_d  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
        cols_rot_d = {cols_q[2:0], cols_q[3]};
        row_pat_d  = ~(4'b0001 << row_q);
    end

    // Decode "exactly one row low"; chords and idle both leave one_low_d clear.
    always_comb begin
        one_low_d = 1'b1;
        row_idx_d = 2'd0;
        case (rs_q)
            4'b1110: row_idx_d = 2'd0;
            4'b1101: row_idx_d = 2'd1;
            4'b1011: row_idx_d = 2'd2;
            4'b0111: row_idx_d = 2'd3;
            default: one_low_d = 1'b0;
        endcase
    end

    // Two-flop synchronizer for the asynchronous row lines (idle = all high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_meta_q <= 4'b1111;
            rs_q      <= 4'b1111;
        end else begin
            rs_meta_q <= rows;
            rs_q      <= rs_meta_q;
        end
    end

    // Scan / debounce / held / release controller with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            cols_q      <= 4'b1110;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (cnt_q >= SCAN_LAST) begin
                        cnt_q <= '0;
                        if (one_low_d) begin
                            // Keep this column driven while the press is qualified.
                            row_q   <= row_idx_d;
                            state_q <= ST_DEBOUNCE;
                        end else begin
                            col_q  <= col_q + 2'd1;
                            cols_q <= cols_rot_d;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs_q != row_pat_d) begin
                        // Bounce or glitch: resume dwelling on the same column.
                        cnt_q   <= '0;
                        state_q <= ST_SCAN;
                    end else if (cnt_q >= DEB_LAST) begin
                        cnt_q       <= '0;
                        key_q       <= key_map(row_q, col_q);
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        state_q     <= ST_HELD;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                ST_HELD: begin
                    cnt_q <= '0;
                    if (rs_q == 4'b1111) begin
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (rs_q != 4'b1111) begin
                        // Release bounce: key is still considered held.
                        cnt_q   <= '0;
                        state_q <= ST_HELD;
                    end else if (cnt_q >= DEB_LAST) begin
                        cnt_q      <= '0;
                        key_held_q <= 1'b0;
                        col_q      <= col_q + 2'd1;
                        cols_q     <= cols_rot_d;
                        state_q    <= ST_SCAN;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_SCAN;
                end
            endcase
        end
    end

    assign cols      = cols_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad model:
// a pressed switch at (r, c) pulls row r low while column c is driven low.
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;   // bit r*4+c : switch at row r, column c closed
    int          checks;
    int          failures;
    int          valid_count;
    int          n;

    keypad_scanner #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key      (key),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model.
    always_comb begin
        rows = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (!cols[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[r*4+c]) rows[r] = 1'b0;
                end
            end
        end
    end

    // Count every cycle key_valid is seen high.
    always @(negedge clk) begin
        if (key_valid) valid_count <= valid_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max, output int cycles);
        cycles = 0;
        while (cycles < max && !key_valid) begin
            tick();
            cycles++;
        end
        check(tag, {31'd0, key_valid}, 32'd1);
        $display("tb: key_valid key=%h after %0d cycles", key, cycles);
    endtask

    task automatic wait_held(input string tag, input logic lvl, input int max, output int cycles);
        cycles = 0;
        while (cycles < max && key_held !== lvl) begin
            tick();
            cycles++;
        end
        check(tag, {31'd0, key_held}, {31'd0, lvl});
        $display("tb: key_held=%0b after %0d cycles", key_held, cycles);
    endtask

    // Wait for the first cycle of a fresh column-0 dwell.
    task automatic sync_col0();
        int k;
        k = 0;
        while (k < 40 && cols == 4'b1110) begin tick(); k++; end
        k = 0;
        while (k < 40 && cols != 4'b1110) begin tick(); k++; end
        check("sync_col0", {28'd0, cols}, 32'h0000000E);
    endtask

    logic [3:0] col_seq [4];

    initial begin
        checks      = 0;
        failures    = 0;
        valid_count = 0;
        pressed     = 16'h0000;
        reset       = 1'b0;
        col_seq[0]  = 4'b1110;
        col_seq[1]  = 4'b1101;
        col_seq[2]  = 4'b1011;
        col_seq[3]  = 4'b0111;

        // Reset state
        repeat (3) tick();
        check("rst_cols", {28'd0, cols}, 32'hE);
        check("rst_key", {28'd0, key}, 32'h0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        $display("tb: reset checked");

        // Row 2 / col 1 held steady -> key 8
        reset = 1'b1;
        pressed[2*4+1] = 1'b1;
        wait_valid("k8_valid", 60, n);
        check("k8_latency", {31'd0, (n <= 4*SCAN + DEB + 4)}, 32'd1);
        check("k8_key", {28'd0, key}, 32'h8);
        check("k8_held", {31'd0, key_held}, 32'd1);
        check("k8_cols", {28'd0, cols}, 32'hD);
        repeat (20) tick();
        check("k8_one_pulse", valid_count, 32'd1);
        check("k8_held_still", {31'd0, key_held}, 32'd1);
        pressed = 16'h0000;
        wait_held("k8_release", 1'b0, 40, n);
        check("k8_next_col", {28'd0, cols}, 32'hB);

        // Short press on row 0 / col 0: rejected, column 0 resumes
        sync_col0();
        pressed[0] = 1'b1;
        repeat (5) tick();
        pressed[0] = 1'b0;
        repeat (3) tick();
        check("short_col0", {28'd0, cols}, 32'hE);
        repeat (30) tick();
        check("short_no_valid", valid_count, 32'd1);
        check("short_key_kept", {28'd0, key}, 32'h8);
        check("short_not_held", {31'd0, key_held}, 32'd0);
        $display("tb: short press rejected");

        // Bouncy press on row 3 / col 1 -> exactly one key 0
        for (int i = 0; i < 20; i++) begin
            pressed[3*4+1] = ((i / 3) % 2 == 0);
            tick();
        end
        pressed[3*4+1] = 1'b1;
        wait_valid("k0_valid", 60, n);
        check("k0_key", {28'd0, key}, 32'h0);
        repeat (10) tick();
        check("k0_one_pulse", valid_count, 32'd2);
        check("k0_held", {31'd0, key_held}, 32'd1);
        pressed = 16'h0000;
        wait_held("k0_release", 1'b0, 40, n);

        // Chord rows 0+1 on col 2: ignored, columns keep cycling
        pressed[0*4+2] = 1'b1;
        pressed[1*4+2] = 1'b1;
        sync_col0();
        for (int i = 0; i < 12; i++) begin
            check($sformatf("chord_cols%0d", i), {28'd0, cols}, {28'd0, col_seq[i % 4]});
            repeat (SCAN) tick();
        end
        check("chord_no_valid", valid_count, 32'd2);
        pressed = 16'h0000;
        $display("tb: chord ignored");

        // Key A with release bounce
        pressed[0*4+3] = 1'b1;
        wait_valid("kA_valid", 60, n);
        check("kA_key", {28'd0, key}, 32'hA);
        repeat (3) tick();
        pressed = 16'h0000;
        repeat (4) tick();
        pressed[0*4+3] = 1'b1;
        repeat (2) tick();
        pressed = 16'h0000;
        check("kA_bounce_held", {31'd0, key_held}, 32'd1);
        wait_held("kA_release", 1'b0, 40, n);
        check("kA_release_restarted", {31'd0, (n >= DEB)}, 32'd1);
        check("kA_wrap_cols", {28'd0, cols}, 32'hE);
        check("kA_one_pulse", valid_count, 32'd3);

        // Key 5 then asynchronous reset while held
        pressed[1*4+1] = 1'b1;
        wait_valid("k5_valid", 60, n);
        check("k5_key", {28'd0, key}, 32'h5);
        repeat (2) tick();
        #1 reset = 1'b0;
        #1;
        check("async_key", {28'd0, key}, 32'h0);
        check("async_held", {31'd0, key_held}, 32'd0);
        check("async_cols", {28'd0, cols}, 32'hE);
        check("async_valid", {31'd0, key_valid}, 32'd0);
        $display("tb: async reset applied");
        pressed = 16'h0000;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("restart_col0", {28'd0, cols}, 32'hE);
        tick();
        check("restart_col1", {28'd0, cols}, 32'hD);
        check("total_pulses", valid_count, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 16, meaning clock cycles each column is driven while scanning (>=4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable cycles required to accept a press or release (>=2).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rows  input  4  keypad row lines; asynchronous; active-low; externally pulled up.
REQ-006 SHALL have port cols  output  4  keypad column drives; active-low; exactly one bit low at all times.
REQ-007 SHALL have port key  output  4  hex code of the last accepted key; this is the value fed to the hex-to-segment decoder.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse marking acceptance of a new key.
REQ-009 SHALL have port key_held  output  1  high from acceptance until the release is debounced.

Function
REQ-010 SHALL pass rows through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-011 SHALL implement states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-012 SCAN: SHALL drive column c (cols bit c low) for SCAN_CYCLES cycles, then advance c to (c+1) mod 4, wrapping from 3 to 0.
REQ-013 SCAN: SHALL sample rs only on the last dwell cycle of each column, so the sample covers the synchronizer latency.
REQ-014 SCAN: at that sample, if exactly one rs bit is low, SHALL capture the row r and column c, hold the column, and enter DEBOUNCE.
REQ-015 SCAN: if zero or two or more rs bits are low, SHALL keep scanning; multi-key chords are ignored.
REQ-016 DEBOUNCE: SHALL count cycles in which rs equals the captured one-hot-low pattern.
REQ-017 DEBOUNCE: any mismatch SHALL return the block to SCAN on the same column with the dwell counter reset, and SHALL NOT assert key_valid.
REQ-018 DEBOUNCE: after DEBOUNCE_CYCLES consecutive matches, SHALL enter HELD on the next cycle.
REQ-019 DEBOUNCE: on that transition, SHALL update key and pulse key_valid high for exactly one cycle.
REQ-020 key map, as (row, col) -> key: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D (columns 0..3).
REQ-021 HELD: SHALL keep the captured column driven and key_held high, and SHALL ignore other keys.
REQ-022 HELD: when rs reads 4'b1111, SHALL enter RELEASE.
REQ-023 RELEASE: SHALL count consecutive cycles of rs == 4'b1111.
REQ-024 RELEASE: if any rs bit goes low, SHALL return to HELD with no new key_valid (bounce on release).
REQ-025 RELEASE: after DEBOUNCE_CYCLES consecutive all-high cycles, SHALL deassert key_held and return to SCAN at column (c+1) mod 4.
REQ-026 key SHALL hold its value until the next accepted press.
REQ-027 Counters SHALL be sized $clog2 of the larger parameter plus 1 and SHALL saturate, never wrap.
REQ-028 Total press latency SHALL be at most 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 4 cycles from a stable press.

Reset
REQ-029 reset low SHALL immediately force: state SCAN, c=0, cols=4'b1110, key=4'h0, key_valid=0, key_held=0, all counters and synchronizer flops cleared (synchronizer to 4'b1111).
REQ-030 Reset asserted mid-DEBOUNCE, HELD or RELEASE SHALL abort without a key_valid pulse; after release scanning SHALL restart at column 0.
REQ-031 Reset deassertion SHALL take effect on the first rising clk edge after it; no output may glitch low-active on cols.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-032 Hold rows=4'b1011 whenever cols=4'b1101 (row 2, col 1) -> one key_valid pulse with key=4'h8, key_held high until release.
REQ-033 Press row 3 col 1, then toggle rows every 3 cycles for 20 cycles before settling -> exactly one key_valid, key=4'h0.
REQ-034 Press row 0 col 0 for 5 cycles only -> no key_valid, key unchanged, scanning resumes on column 0.
REQ-035 Rows 0 and 1 both low on col 2 -> no key_valid ever; cols keeps cycling 1110->1101->1011->0111->1110.
REQ-036 Accept key A (row 0, col 3); during RELEASE drop row 0 for 2 cycles -> back to HELD, no second pulse; final release -> key_held=0, cols=4'b1110.
REQ-037 Assert reset during HELD with key=4'h5 -> key=4'h0, key_held=0, cols=4'b1110 immediately, without waiting for clk.
